// File: rtl/regbank_wr_arb_if.sv
// Write-request bundle between the requesters and the regbank write-port arbiter.
// Handshake: a requester holds req with addr/data stable; the beat transfers on the rising edge where req & gnt.
interface regbank_wr_arb_if #(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int REGS = 16,
    parameter int AW   = 4
);
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*W-1:0]  data;
    logic [N-1:0]    gnt;
    logic [W-1:0]    inp;
    logic [REGS-1:0] wen;
    logic            busy;
    logic            err;
    logic            st_dbg;

    modport master (
        output req, lock, addr, data,
        input  gnt, inp, wen, busy, err, st_dbg
    );

    modport slave (
        input  req, lock, addr, data,
        output gnt, inp, wen, busy, err, st_dbg
    );
endinterface

// File: rtl/regbank_wr_arb.sv
// Round-robin arbiter for the single regbank write port, with short locked bursts.
// Drives registered inp/wen one cycle after each accepted beat.
module regbank_wr_arb #(
    parameter int N         = 4,
    parameter int W         = 16,
    parameter int REGS      = 16,
    parameter int AW        = 4,
    parameter int MAX_BURST = 4
) (
    input logic             ck,
    input logic             rn,
    regbank_wr_arb_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} st_t;

    st_t             st_q, st_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic [W-1:0]    inp_q;
    logic [REGS-1:0] wen_q, wen_d;
    logic            busy_q;
    logic            err_q;

    logic [N-1:0]    gnt_c;
    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   sel;
    logic [AW-1:0]   sel_addr;
    logic [W-1:0]    sel_data;
    logic            in_range;
    logic            acc;

    // First requester at or after ptr+1, wrapping, so the last winner has lowest priority.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        beats_d = beats_q;
        gnt_c   = '0;
        sel     = win;
        case (st_q)
            IDLE: begin
                if (found) begin
                    gnt_c[win] = 1'b1;
                    ptr_d      = win;
                    if (bus.lock[win]) begin
                        st_d    = BURST;
                        owner_d = win;
                        beats_d = BW'(1);
                    end
                end
            end
            BURST: begin
                sel = owner_q;
                if (bus.req[owner_q]) begin
                    gnt_c[owner_q] = 1'b1;
                    beats_d        = beats_q + 1'b1;
                    // Lock is ignored on the beat that reaches the burst limit.
                    if (!bus.lock[owner_q] || (int'(beats_q) + 1 >= MAX_BURST)) begin
                        st_d    = IDLE;
                        beats_d = '0;
                    end
                end else begin
                    st_d    = IDLE;
                    beats_d = '0;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign acc      = |gnt_c;
    assign sel_addr = bus.addr[int'(sel)*AW +: AW];
    assign sel_data = bus.data[int'(sel)*W +: W];
    assign in_range = int'(sel_addr) < REGS;

    always_comb begin
        wen_d = '0;
        if (acc && in_range) begin
            wen_d = REGS'(1) << sel_addr;
        end
    end

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            st_q    <= IDLE;
            ptr_q   <= PW'(N - 1);
            owner_q <= '0;
            beats_q <= '0;
            inp_q   <= '0;
            wen_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
            wen_q   <= wen_d;
            busy_q  <= (st_d == BURST);
            err_q   <= acc && !in_range;
            if (acc) begin
                inp_q <= sel_data;
            end
        end
    end

    // Grant is masked during reset so nothing can be accepted while the burst is abandoned.
    assign bus.gnt    = rn ? gnt_c : '0;
    assign bus.inp    = inp_q;
    assign bus.wen    = wen_q;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;
    assign bus.st_dbg = (st_q == BURST);
endmodule

// File: tb/tb_regbank_wr_arb.sv
// Directed bench for regbank_wr_arb: round-robin, single requester, locked bursts,
// dropped burst, mid-burst reset and out-of-range address on a REGS=15 instance.
module tb_regbank_wr_arb;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int MB = 4;

  logic ck = 1'b0;
  logic rn = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [W-1:0] exp_q[$];

  always #5 ck = ~ck;

  regbank_wr_arb_if #(.N(N), .W(W), .REGS(16), .AW(AW)) a ();
  regbank_wr_arb_if #(.N(N), .W(W), .REGS(15), .AW(AW)) b ();

  assign b.req  = a.req;
  assign b.lock = a.lock;
  assign b.addr = a.addr;
  assign b.data = a.data;

  regbank_wr_arb #(.N(N), .W(W), .REGS(16), .AW(AW), .MAX_BURST(MB)) dut (
    .ck  (ck),
    .rn  (rn),
    .bus (a.slave)
  );

  regbank_wr_arb #(.N(N), .W(W), .REGS(15), .AW(AW), .MAX_BURST(MB)) dut15 (
    .ck  (ck),
    .rn  (rn),
    .bus (b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input logic [AW-1:0] ad, input logic [W-1:0] d);
    a.addr[i*AW +: AW] = ad;
    a.data[i*W +: W]   = d;
  endtask

  task automatic next_cycle();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [15:0] oh(input int n);
    logic [15:0] one;
    one = 16'd1;
    return one << n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    a.req  = 4'b1111;
    a.lock = 4'b0000;
    for (int i = 0; i < N; i++) set_lane(i, AW'(i + 4), W'(16'h1000 + i));

    // Reset state, with requests pending.
    #12;
    check("rst_gnt", 32'(a.gnt), 32'h0);
    check("rst_wen", 32'(a.wen), 32'h0);
    check("rst_inp", 32'(a.inp), 32'h0);
    check("rst_busy", 32'(a.busy), 32'h0);
    check("rst_err", 32'(a.err), 32'h0);
    a.req = 4'b0000;
    @(negedge ck);
    rn = 1'b1;
    next_cycle();

    // Round robin with all four requesting: 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 10; k++) begin
      a.req = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge ck);
      check("rr_gnt", 32'(a.gnt), (k < 8) ? 32'(oh(k % 4)) : 32'h0);
      if (k >= 1) begin
        check("rr_wen", 32'(a.wen), (k <= 8) ? 32'(oh(4 + (k - 1) % 4)) : 32'h0);
        if (k <= 8) check("rr_inp", 32'(a.inp), 32'(exp_q.pop_front()));
      end
      if (k < 8) exp_q.push_back(W'(16'h1000 + k % 4));
      next_cycle();
    end

    // Requester 2 alone.
    set_lane(2, 4'd5, 16'habcd);
    a.req = 4'b0100;
    @(negedge ck);
    check("solo_gnt", 32'(a.gnt), 32'h4);
    next_cycle();
    a.req = 4'b0000;
    @(negedge ck);
    check("solo_wen", 32'(a.wen), 32'h0020);
    check("solo_inp", 32'(a.inp), 32'habcd);
    next_cycle();
    @(negedge ck);
    check("solo_wen0", 32'(a.wen), 32'h0);
    next_cycle();

    // Move ptr to 0, then requester 1 bursts with lock held; limited to MAX_BURST.
    a.req = 4'b0001;
    @(negedge ck);
    check("pre_gnt", 32'(a.gnt), 32'h1);
    next_cycle();
    a.req  = 4'b1111;
    a.lock = 4'b0010;
    for (int j = 0; j < 5; j++) begin
      @(negedge ck);
      check("bst_gnt", 32'(a.gnt), (j < 4) ? 32'h2 : 32'h4);
      check("bst_busy", 32'(a.busy), (j >= 1 && j <= 3) ? 32'h1 : 32'h0);
      check("bst_wen", 32'(a.wen), (j == 0) ? 32'h0010 : 32'h0020);
      next_cycle();
    end
    a.req  = 4'b0000;
    a.lock = 4'b0000;
    @(negedge ck);
    check("bst_end_busy", 32'(a.busy), 32'h0);
    check("bst_end_inp", 32'(a.inp), 32'habcd);
    next_cycle();

    // Requester 3 locks, then drops req: one bubble, then search restarts at 0.
    a.req  = 4'b1000;
    a.lock = 4'b1000;
    @(negedge ck);
    check("drop_gnt0", 32'(a.gnt), 32'h8);
    check("drop_busy0", 32'(a.busy), 32'h0);
    next_cycle();
    @(negedge ck);
    check("drop_gnt1", 32'(a.gnt), 32'h8);
    check("drop_busy1", 32'(a.busy), 32'h1);
    check("drop_wen1", 32'(a.wen), 32'h0080);
    next_cycle();
    a.req  = 4'b0011;
    a.lock = 4'b0000;
    @(negedge ck);
    check("drop_bubble", 32'(a.gnt), 32'h0);
    check("drop_busy2", 32'(a.busy), 32'h1);
    next_cycle();
    @(negedge ck);
    check("drop_gnt3", 32'(a.gnt), 32'h1);
    check("drop_busy3", 32'(a.busy), 32'h0);
    check("drop_wen3", 32'(a.wen), 32'h0);
    next_cycle();

    // Mid-burst asynchronous reset.
    a.req  = 4'b0010;
    a.lock = 4'b0010;
    @(negedge ck);
    check("mr_wen_prev", 32'(a.wen), 32'h0010);
    check("mr_gnt0", 32'(a.gnt), 32'h2);
    next_cycle();
    @(negedge ck);
    check("mr_gnt1", 32'(a.gnt), 32'h2);
    check("mr_busy1", 32'(a.busy), 32'h1);
    check("mr_inp1", 32'(a.inp), 32'h1001);
    @(posedge ck);
    #2;
    rn     = 1'b0;
    a.req  = 4'b1111;
    a.lock = 4'b0000;
    #1;
    check("mr_wen", 32'(a.wen), 32'h0);
    check("mr_inp", 32'(a.inp), 32'h0);
    check("mr_busy", 32'(a.busy), 32'h0);
    check("mr_gnt", 32'(a.gnt), 32'h0);
    @(negedge ck);
    rn = 1'b1;
    #1;
    check("mr_prio0", 32'(a.gnt), 32'h1);
    next_cycle();

    // Out-of-range address on the REGS=15 instance.
    set_lane(0, 4'hf, 16'hbeef);
    a.req = 4'b0001;
    @(negedge ck);
    check("oor_wen_prev", 32'(a.wen), 32'h0010);
    check("oor_inp_prev", 32'(a.inp), 32'h1000);
    check("oor_gnt15", 32'(b.gnt), 32'h1);
    next_cycle();
    a.req = 4'b0000;
    @(negedge ck);
    check("oor_wen15", 32'(b.wen), 32'h0);
    check("oor_err15", 32'(b.err), 32'h1);
    check("oor_wen16", 32'(a.wen), 32'h8000);
    check("oor_err16", 32'(a.err), 32'h0);
    check("oor_inp16", 32'(a.inp), 32'hbeef);
    next_cycle();
    @(negedge ck);
    check("oor_err15_off", 32'(b.err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/regbank_wr_arb.md
# regbank_wr_arb

Write-port arbiter for `regbank`. Up to N requesters (SIMD lanes, load unit, host loader) share the bank's single write port. The arbiter grants one request per cycle in round-robin order and supports short locked bursts for vector writeback. It drives the `inp`/`wen` pins of `regbank` from registered outputs. Read ports (`sel1`/`sel2`) are not touched.

## Interface
- `N`, 4: number of write requesters.
- `W`, 16: data width; matches `regbank` `inp`.
- `REGS`, 16: number of registers; width of one-hot `wen`.
- `AW`, 4: register address width per requester.
- `MAX_BURST`, 4: maximum beats in one locked burst (≥2).

Ports:
- `ck` in 1: clock.
- `rn` in 1: reset, asynchronous, active-low.
- `req` in N: per-requester write request; held with `addr`/`data` stable until granted.
- `lock` in N: requester wants to keep ownership after this beat.
- `addr` in N*AW: requester i address at bits [i*AW +: AW].
- `data` in N*W: requester i data at bits [i*W +: W].
- `gnt` out N: combinational one-hot accept; beat i transfers when `req[i] & gnt[i]`.
- `inp` out W: registered write data to `regbank`.
- `wen` out REGS: registered one-hot write enable to `regbank`.
- `busy` out 1: registered; high while in BURST.
- `err` out 1: registered one-cycle pulse when a granted beat had `addr >= REGS`.

## Operation
- State is `ptr` (last granted index), `st` ∈ {IDLE, BURST}, `owner`, and `beats` (burst beat counter).
- IDLE:
  - The winner is the first requester with `req` high, searching from `ptr+1` mod N upward with wrap.
  - `gnt[winner]` is asserted and `ptr` ← winner.
  - If `lock[winner]` is high: go to BURST, `owner` ← winner, `beats` ← 1.
- BURST:
  - Only `owner` may be granted. `gnt[owner] = req[owner]`; all other requesters see `gnt` = 0.
  - Each accepted beat increments `beats`.
  - Exit to IDLE after the cycle in which any of these holds:
    - an accepted beat has `lock[owner]` = 0;
    - `beats` reaches MAX_BURST on an accepted beat;
    - `req[owner]` = 0. No grant is given that cycle; the bubble is intended.
  - On exit, `ptr` stays at `owner`, so the next IDLE search starts at `owner+1`.
- Accepted beat: on the next edge, `inp` ← data of the granted requester and `wen` ← one-hot(`addr`). Otherwise `wen` ← 0 and `inp` holds its value.
- Out-of-range address (`addr >= REGS`): the beat is still granted, `wen` ← 0 and `err` ← 1 for one cycle. Burst counting is unaffected.
- `lock` is ignored on the final beat forced by MAX_BURST; the requester must re-arbitrate.
- Reset while `rn` low (asynchronous): `st`=IDLE, `ptr`=N-1 (so requester 0 has first priority), `owner`=0, `beats`=0, `inp`=0, `wen`=0, `busy`=0, `err`=0, `gnt`=0. A burst in progress is abandoned and no partial write is emitted.

## Timing
- `gnt` is combinational from `req`, `lock` and the registered state, with no added cycle. Requesters advance on the rising edge where `req & gnt` holds.
- Write latency: a beat accepted in cycle t gives `wen`/`inp` valid during cycle t+1, and `regbank` captures it at the end of t+1.
- Throughput: one write per cycle, both in IDLE with continuous requests and inside a burst.
- The last beat of a burst is accepted in cycle t; IDLE arbitration happens in cycle t+1, so there is no lost cycle.
- `busy` goes high the cycle after the grant that opened the burst. It goes low the cycle after exit.
- Every write is visible one cycle later than the same write through a direct `regbank` connection; no data forwarding is provided.

## Test plan
- Reset, then release `rn`; raise `req`=4'b1111 with `lock`=0 for 8 cycles → `gnt` sequence 0,1,2,3,0,1,2,3. Each `wen` = one-hot(addr) one cycle after its grant, `inp` = matching data.
- Requester 2 alone: `req`=4'b0100, `addr`=5, `data`=16'habcd → `gnt`=4'b0100 in the same cycle. Next cycle `wen`=16'h0020 and `inp`=16'habcd, then `wen`=0.
- Requester 1 locks with `lock` held high for 6 beats while `req`=4'b1111 → requester 1 gets 4 consecutive grants (MAX_BURST) and `busy` is high during the burst. Requester 2 is granted on the next cycle.
- Requester 3 locks, then drops `req` after 2 beats → one bubble cycle with `gnt`=0, then IDLE arbitration resumes starting from requester 0.
- Assert `rn` low mid-burst, between clock edges → `wen`, `inp`, `busy`, `gnt` go to 0 immediately. After release, requester 0 has priority.
- `addr`=4'hF with `REGS`=15 → `gnt` is given, `wen`=0 and `err`=1 for exactly one cycle.
